ro_sample_ctrl: RTL
===================

RO_SAMPLE_CTRL -- requirements
Module: ro_sample_ctrl

Interface
REQ-001 SHALL have parameter SIZE_WIDTH, default 32: width of num_samples, collect_cycles and internal counters.
REQ-002 SHALL have parameter COUNT_WIDTH, default 32: width of ring-oscillator count and wr_data.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port go  input  1  single-cycle start pulse from MMIO.
REQ-006 SHALL have port num_samples  input  SIZE_WIDTH  number of samples to produce.
REQ-007 SHALL have port collect_cycles  input  SIZE_WIDTH  RO count window length, in clk cycles.
REQ-008 SHALL have port switcher_en  input  1  enables switcher activity during windows.
REQ-009 SHALL have port rsa_go  input  1  level; requests an RSA start pulse per run.
REQ-010 SHALL have port ro_clr  output  1  clears the RO edge counter.
REQ-011 SHALL have port ro_en  output  1  enables RO edge counting.
REQ-012 SHALL have port ro_count  input  COUNT_WIDTH  current RO edge count.
REQ-013 SHALL have port wr_valid  output  1  sample valid towards DMA write path.
REQ-014 SHALL have port wr_ready  input  1  DMA write path accepts the sample.
REQ-015 SHALL have port wr_data  output  COUNT_WIDTH  captured sample.
REQ-016 SHALL have port rsa_start  output  1  single-cycle RSA start pulse.
REQ-017 SHALL have port switcher_act  output  1  switcher activity enable.
REQ-018 SHALL have port busy  output  1  run in progress.
REQ-019 SHALL have port done  output  1  run complete; status bit read back by software.

Function
REQ-020 SHALL implement states IDLE, CLEAR, COLLECT, CAPTURE, WRITE, FINISH.
REQ-021 SHALL, in IDLE on go with num_samples != 0, latch num_samples and collect_cycles, clear done, zero the sample index and enter CLEAR.
REQ-022 SHALL, in IDLE on go with num_samples == 0, set done on the next cycle and remain in IDLE.
REQ-023 SHALL ignore go in every state other than IDLE; latched configuration is unaffected by input changes mid-run.
REQ-024 SHALL assert ro_clr for exactly one cycle in CLEAR, load the window counter and enter COLLECT.
REQ-025 SHALL assert ro_en for exactly max(collect_cycles,1) consecutive cycles in COLLECT, then enter CAPTURE.
REQ-026 SHALL deassert ro_en in CAPTURE, register ro_count into wr_data at the end of that cycle and enter WRITE.
REQ-027 SHALL hold wr_valid high and wr_data stable in WRITE until wr_valid && wr_ready.
REQ-028 SHALL, on a handshake, increment the sample index and enter FINISH if the index equals latched num_samples-1, else CLEAR.
REQ-029 SHALL, in FINISH, set done (held until the next accepted go) and return to IDLE the next cycle.
REQ-030 SHALL pulse rsa_start for one cycle in the first CLEAR of a run when rsa_go is high at the accepting go.
REQ-031 SHALL drive busy high in every state except IDLE.
REQ-032 SHALL wrap no counter; index and window counters are SIZE_WIDTH bits and cover up to 2**SIZE_WIDTH-1.

Reset
REQ-033 SHALL, on rst, enter IDLE and drive ro_clr, ro_en, wr_valid, wr_data, rsa_start, switcher_act, busy and done to 0.
REQ-034 SHALL, on rst mid-run, abandon the run immediately: no further wr_valid and done stays 0.

Configuration
REQ-035 SHALL, with RO_SWITCHER_EN defined, drive switcher_act = switcher_en && (state == COLLECT), registered with ro_en.
REQ-036 SHALL, without RO_SWITCHER_EN, tie switcher_act to 0 and ignore switcher_en.

Verification
REQ-037 SHALL cover go, num_samples=3, collect_cycles=4, wr_ready=1, ro_count ramping -> three wr_valid beats, each preceded by 4 ro_en cycles; done=1 after the third beat.
REQ-038 SHALL cover go with num_samples=0 -> done=1 one cycle later; busy, ro_en and wr_valid stay 0.
REQ-039 SHALL cover num_samples=2 with wr_ready low for 5 cycles on the first beat -> wr_data stable and wr_valid held; no second ro_clr until after the handshake.
REQ-040 SHALL cover collect_cycles=0 -> ro_en high for exactly 1 cycle per sample.
REQ-041 SHALL cover go and rsa_go=1 pulsed mid-run, then rst asserted during COLLECT -> second go ignored, one rsa_start only; after rst all outputs 0, done 0 and next go starts cleanly.
REQ-042 SHALL cover, with RO_SWITCHER_EN defined, switcher_en=1 -> switcher_act equals ro_en; without the macro -> switcher_act constantly 0.

Source files
------------

// File: rtl/ro_sample_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ro_sample_ctrl
//  Description : Sequencer for ring-oscillator sampling runs. On a go pulse,
//                it produces num_samples samples. For each sample it clears
//                the RO edge counter, then lets the counter run for a window
//                of collect_cycles clocks. It then captures the count and
//                hands the count to the DMA write path with a valid/ready
//                handshake. An optional RSA start pulse fires at the
//                beginning of a run.
//
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                go                  - single-cycle run start (IDLE only)
//                num_samples         - samples per run (0 = immediate done)
//                collect_cycles      - count window length (0 treated as 1)
//                switcher_en         - switcher activity request
//                rsa_go              - request an rsa_start pulse per run
//                ro_clr, ro_en       - RO edge counter clear / enable
//                ro_count            - RO edge counter value
//                wr_valid, wr_ready  - sample handshake towards DMA
//                wr_data             - captured sample
//                rsa_start           - one-cycle RSA start pulse
//                switcher_act        - switcher activity enable
//                busy, done          - run status
//
//  Options     : RO_SWITCHER_EN - when defined, switcher_act follows ro_en
//                                 gated by switcher_en; otherwise tied low.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module ro_sample_ctrl #(
    parameter int SIZE_WIDTH  = 32,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    input  logic [SIZE_WIDTH-1:0]  num_samples,
    input  logic [SIZE_WIDTH-1:0]  collect_cycles,
    input  logic                   switcher_en,
    input  logic                   rsa_go,
    output logic                   ro_clr,
    output logic                   ro_en,
    input  logic [COUNT_WIDTH-1:0] ro_count,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [COUNT_WIDTH-1:0] wr_data,
    output logic                   rsa_start,
    output logic                   switcher_act,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_COLLECT = 3'd2,
        S_CAPTURE = 3'd3,
        S_WRITE   = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    localparam logic [SIZE_WIDTH-1:0] c_one = SIZE_WIDTH'(1);

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [SIZE_WIDTH-1:0]    r_num;
    logic [SIZE_WIDTH-1:0]    r_cycles;
    logic [SIZE_WIDTH-1:0]    r_win;
    logic [SIZE_WIDTH-1:0]    r_idx;

    logic                     r_ro_clr;
    logic                     r_ro_en;
    logic                     r_wr_valid;
    logic [COUNT_WIDTH-1:0]   r_wr_data;
    logic                     r_rsa_start;
    logic                     r_switcher_act;
    logic                     r_busy;
    logic                     r_done;

    logic                     w_accept;
    logic                     w_zero_go;
    logic                     w_handshake;
    logic                     w_last;
    logic [SIZE_WIDTH-1:0]    w_win_load;
    logic                     w_ro_clr_nxt;
    logic                     w_ro_en_nxt;
    logic                     w_wr_valid_nxt;
    logic                     w_rsa_nxt;
    logic                     w_sw_nxt;
    logic                     w_busy_nxt;
    logic                     w_unused;

    assign w_accept    = (r_state == S_IDLE) && go && (num_samples != '0);
    assign w_zero_go   = (r_state == S_IDLE) && go && (num_samples == '0);
    // r_wr_valid is only ever high while in WRITE.
    assign w_handshake = r_wr_valid && wr_ready;
    // r_num is non-zero whenever a run is active, so num-1 cannot underflow.
    assign w_last      = (r_idx == (r_num - c_one));
    // A zero window still counts for one cycle.
    assign w_win_load  = (r_cycles == '0) ? c_one : r_cycles;
    assign w_unused    = switcher_en;

    // Next state and next-cycle output values. Outputs are registered from
    // the next state so that they line up exactly with the state they decode.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:    if (w_accept) w_state_nxt = S_CLEAR;
            S_CLEAR:   w_state_nxt = S_COLLECT;
            S_COLLECT: if (r_win == c_one) w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_WRITE;
            S_WRITE:   if (w_handshake) w_state_nxt = w_last ? S_FINISH : S_CLEAR;
            S_FINISH:  w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase

        w_ro_clr_nxt   = (w_state_nxt == S_CLEAR);
        w_ro_en_nxt    = (w_state_nxt == S_COLLECT);
        w_wr_valid_nxt = (w_state_nxt == S_WRITE);
        w_busy_nxt     = (w_state_nxt != S_IDLE);
        // Only the IDLE->CLEAR entry is the first CLEAR of a run.
        w_rsa_nxt      = w_accept && rsa_go;
`ifdef RO_SWITCHER_EN
        w_sw_nxt       = switcher_en && (w_state_nxt == S_COLLECT);
`else
        w_sw_nxt       = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_num          <= '0;
            r_cycles       <= '0;
            r_win          <= '0;
            r_idx          <= '0;
            r_ro_clr       <= 1'b0;
            r_ro_en        <= 1'b0;
            r_wr_valid     <= 1'b0;
            r_wr_data      <= '0;
            r_rsa_start    <= 1'b0;
            r_switcher_act <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_ro_clr       <= w_ro_clr_nxt;
            r_ro_en        <= w_ro_en_nxt;
            r_wr_valid     <= w_wr_valid_nxt;
            r_rsa_start    <= w_rsa_nxt;
            r_switcher_act <= w_sw_nxt;
            r_busy         <= w_busy_nxt;

            if (w_accept) begin
                r_num    <= num_samples;
                r_cycles <= collect_cycles;
                r_done   <= 1'b0;
            end else if (w_zero_go || (r_state == S_FINISH)) begin
                r_done   <= 1'b1;
            end

            if (w_accept) begin
                r_idx <= '0;
            end else if (w_handshake) begin
                r_idx <= r_idx + c_one;
            end

            if (r_state == S_CLEAR) begin
                r_win <= w_win_load;
            end else if (r_state == S_COLLECT) begin
                r_win <= r_win - c_one;
            end

            // ro_en is already low in CAPTURE, so the count is settled.
            if (r_state == S_CAPTURE) begin
                r_wr_data <= ro_count;
            end
        end
    end

    assign ro_clr       = r_ro_clr;
    assign ro_en        = r_ro_en;
    assign wr_valid     = r_wr_valid;
    assign wr_data      = r_wr_data;
    assign rsa_start    = r_rsa_start;
    assign switcher_act = r_switcher_act;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule
`default_nettype wire
